// File: rtl/cfo_ctrl_pkg.sv
// Shared definitions for the CFO loop acquisition/tracking controller.
// - cfo_state_e: controller state, encoding visible on state_o.
// - Default loop gains and thresholds used as parameter defaults.
// - sat_inc_retry: saturating increment for the retry counter.
package cfo_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFlush = 2'd1,
    StAcq   = 2'd2,
    StTrack = 2'd3
  } cfo_state_e;

  localparam int unsigned RetryWidth = 8;

  localparam int unsigned KpAcqDef = 1288;
  localparam int unsigned KiAcqDef = 208;
  localparam int unsigned KpTrkDef = 322;
  localparam int unsigned KiTrkDef = 13;

  localparam int unsigned LockThrDef   = 2 ** 18;
  localparam int unsigned UnlockThrDef = 2 ** 20;

  function automatic logic [RetryWidth-1:0] sat_inc_retry(input logic [RetryWidth-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/err_mag_cmp.sv
// Phase-error magnitude and lock/unlock threshold compare (combinational).
// Ports:
//   phase_err_i - signed two's-complement phase error
//   in_lock_o   - |err| <= LOCK_THR
//   out_lock_o  - |err| >  UNLOCK_THR
module err_mag_cmp #(
  parameter int unsigned ERR_WIDTH  = 24,
  parameter int unsigned LOCK_THR   = 2 ** 18,
  parameter int unsigned UNLOCK_THR = 2 ** 20
) (
  input  logic [ERR_WIDTH-1:0] phase_err_i,
  output logic                 in_lock_o,
  output logic                 out_lock_o
);

  localparam int unsigned MagW = ERR_WIDTH - 1;
  localparam logic [MagW-1:0] LockThr   = MagW'(LOCK_THR);
  localparam logic [MagW-1:0] UnlockThr = MagW'(UNLOCK_THR);

  logic [MagW-1:0] mag;

  always_comb begin
    if (!phase_err_i[ERR_WIDTH-1]) begin
      mag = phase_err_i[MagW-1:0];
    end else if (phase_err_i[MagW-1:0] == '0) begin
      // Most negative code has no positive twin; clamp to full scale.
      mag = '1;
    end else begin
      mag = ~phase_err_i[MagW-1:0] + 1'b1;
    end
    in_lock_o  = (mag <= LockThr);
    out_lock_o = (mag > UnlockThr);
  end

endmodule

// File: rtl/cfo_loop_ctrl.sv
// Gear-shift controller for the CFO PI loop filter.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   enable_i       - run controller; low forces IDLE
//   err_valid_i    - phase error strobe
//   phase_err_i    - signed phase error
//   kp_coeff_o     - proportional gain to filter (ACQ or TRK)
//   ki_coeff_o     - integral gain to filter (ACQ or TRK)
//   loop_rst_o     - filter integrator clear, high in IDLE/FLUSH
//   locked_o       - high in TRACK
//   state_o        - IDLE=0, FLUSH=1, ACQ=2, TRACK=3
//   retry_cnt_o    - ACQ timeouts since leaving IDLE, saturating
module cfo_loop_ctrl
  import cfo_ctrl_pkg::*;
#(
  parameter int unsigned ERR_WIDTH   = 24,
  parameter int unsigned COEFF_WIDTH = 16,
  parameter int unsigned KP_ACQ      = KpAcqDef,
  parameter int unsigned KI_ACQ      = KiAcqDef,
  parameter int unsigned KP_TRK      = KpTrkDef,
  parameter int unsigned KI_TRK      = KiTrkDef,
  parameter int unsigned LOCK_THR    = LockThrDef,
  parameter int unsigned UNLOCK_THR  = UnlockThrDef,
  parameter int unsigned LOCK_CNT    = 256,
  parameter int unsigned UNLOCK_CNT  = 64,
  parameter int unsigned ACQ_TIMEOUT = 8192,
  parameter int unsigned FLUSH_LEN   = 4,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable_i,
  input  logic                   err_valid_i,
  input  logic [ERR_WIDTH-1:0]   phase_err_i,
  output logic [COEFF_WIDTH-1:0] kp_coeff_o,
  output logic [COEFF_WIDTH-1:0] ki_coeff_o,
  output logic                   loop_rst_o,
  output logic                   locked_o,
  output logic [1:0]             state_o,
  output logic [RetryWidth-1:0]  retry_cnt_o
);

  localparam logic [CNT_WIDTH-1:0] FlushLast  = CNT_WIDTH'(FLUSH_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] LockCnt    = CNT_WIDTH'(LOCK_CNT);
  localparam logic [CNT_WIDTH-1:0] UnlockCnt  = CNT_WIDTH'(UNLOCK_CNT);
  localparam logic [CNT_WIDTH-1:0] AcqTimeout = CNT_WIDTH'(ACQ_TIMEOUT);

  localparam logic [COEFF_WIDTH-1:0] KpAcq = COEFF_WIDTH'(KP_ACQ);
  localparam logic [COEFF_WIDTH-1:0] KiAcq = COEFF_WIDTH'(KI_ACQ);
  localparam logic [COEFF_WIDTH-1:0] KpTrk = COEFF_WIDTH'(KP_TRK);
  localparam logic [COEFF_WIDTH-1:0] KiTrk = COEFF_WIDTH'(KI_TRK);

  cfo_state_e state_q, state_d;
  logic [CNT_WIDTH-1:0] flush_q, flush_d;
  logic [CNT_WIDTH-1:0] lock_q, lock_d, lock_inc;
  logic [CNT_WIDTH-1:0] tmo_q, tmo_d, tmo_inc;
  logic [CNT_WIDTH-1:0] unl_q, unl_d, unl_inc;
  logic [RetryWidth-1:0] retry_q, retry_d;

  logic loop_rst_q, loop_rst_d;
  logic locked_q, locked_d;
  logic [COEFF_WIDTH-1:0] kp_q, kp_d, ki_q, ki_d;

  logic in_lock, out_lock;

  err_mag_cmp #(
    .ERR_WIDTH  (ERR_WIDTH),
    .LOCK_THR   (LOCK_THR),
    .UNLOCK_THR (UNLOCK_THR)
  ) u_err_mag_cmp (
    .phase_err_i (phase_err_i),
    .in_lock_o   (in_lock),
    .out_lock_o  (out_lock)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      flush_q <= '0;
      lock_q  <= '0;
      tmo_q   <= '0;
      unl_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      lock_q  <= lock_d;
      tmo_q   <= tmo_d;
      unl_q   <= unl_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    flush_d  = flush_q;
    lock_d   = lock_q;
    tmo_d    = tmo_q;
    unl_d    = unl_q;
    retry_d  = retry_q;
    lock_inc = in_lock ? lock_q + 1'b1 : '0;
    tmo_inc  = tmo_q + 1'b1;
    unl_inc  = out_lock ? unl_q + 1'b1 : '0;

    unique case (state_q)
      StIdle: begin
        if (enable_i) begin
          state_d = StFlush;
          retry_d = '0;
        end
      end
      StFlush: begin
        if (flush_q == FlushLast) begin
          state_d = StAcq;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
      StAcq: begin
        if (err_valid_i) begin
          lock_d = lock_inc;
          tmo_d  = tmo_inc;
          // Lock is tested first so it wins over a coincident timeout.
          if (lock_inc == LockCnt) begin
            state_d = StTrack;
          end else if (tmo_inc == AcqTimeout) begin
            state_d = StFlush;
            retry_d = sat_inc_retry(retry_q);
          end
        end
      end
      StTrack: begin
        if (err_valid_i) begin
          unl_d = unl_inc;
          if (unl_inc == UnlockCnt) begin
            state_d = StAcq;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (!enable_i) begin
      state_d = StIdle;
      retry_d = retry_q;
    end

    // Every state entry starts with fresh sample/flush counters.
    if (state_d != state_q) begin
      flush_d = '0;
      lock_d  = '0;
      tmo_d   = '0;
      unl_d   = '0;
    end
  end

  // Outputs are decoded from the next state and registered, so they change on
  // the same edge as state_q.
  always_comb begin
    loop_rst_d = 1'b0;
    locked_d   = 1'b0;
    kp_d       = KpAcq;
    ki_d       = KiAcq;
    unique case (state_d)
      StIdle, StFlush: loop_rst_d = 1'b1;
      StAcq:           loop_rst_d = 1'b0;
      StTrack: begin
        locked_d = 1'b1;
        kp_d     = KpTrk;
        ki_d     = KiTrk;
      end
      default: loop_rst_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loop_rst_q <= 1'b1;
      locked_q   <= 1'b0;
      kp_q       <= KpAcq;
      ki_q       <= KiAcq;
    end else begin
      loop_rst_q <= loop_rst_d;
      locked_q   <= locked_d;
      kp_q       <= kp_d;
      ki_q       <= ki_d;
    end
  end

  assign kp_coeff_o  = kp_q;
  assign ki_coeff_o  = ki_q;
  assign loop_rst_o  = loop_rst_q;
  assign locked_o    = locked_q;
  assign state_o     = state_q;
  assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_cfo_loop_ctrl.sv
// Self-checking bench for cfo_loop_ctrl: directed scenarios plus randomized
// traffic, all compared each cycle against a behavioural model.
module tb_cfo_loop_ctrl;

  localparam int LockCnt    = 8;
  localparam int UnlockCnt  = 4;
  localparam int AcqTimeout = 32;
  localparam int FlushLen   = 4;
  localparam int LockThr    = 1000;
  localparam int UnlockThr  = 5000;
  localparam int ErrMax     = 2 ** 23 - 1;
  localparam int ErrMin     = -(2 ** 23);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_i = 1'b0;
  logic        err_valid_i = 1'b0;
  logic [23:0] phase_err_i = '0;
  logic [15:0] kp_coeff_o, ki_coeff_o;
  logic        loop_rst_o, locked_o;
  logic [1:0]  state_o;
  logic [7:0]  retry_cnt_o;

  int total = 0;
  int bad   = 0;

  // Model state: mode 0..3 = IDLE/FLUSH/ACQ/TRACK.
  int m_mode, m_run, m_seen, m_bad_run, m_age, m_retry;

  always #5 clk = ~clk;

  cfo_loop_ctrl #(
    .LOCK_THR    (LockThr),
    .UNLOCK_THR  (UnlockThr),
    .LOCK_CNT    (LockCnt),
    .UNLOCK_CNT  (UnlockCnt),
    .ACQ_TIMEOUT (AcqTimeout),
    .FLUSH_LEN   (FlushLen)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable_i    (enable_i),
    .err_valid_i (err_valid_i),
    .phase_err_i (phase_err_i),
    .kp_coeff_o  (kp_coeff_o),
    .ki_coeff_o  (ki_coeff_o),
    .loop_rst_o  (loop_rst_o),
    .locked_o    (locked_o),
    .state_o     (state_o),
    .retry_cnt_o (retry_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit en, input bit vld, input int e);
    int nxt;
    int mag;
    mag = (e < 0) ? -e : e;
    if (mag > ErrMax) mag = ErrMax;
    nxt = m_mode;
    if (r) begin
      nxt = 0;
      m_retry = 0;
    end else if (!en) begin
      nxt = 0;
    end else begin
      case (m_mode)
        0: begin
          nxt = 1;
          m_retry = 0;
        end
        1: begin
          m_age++;
          if (m_age >= FlushLen) nxt = 2;
        end
        2: if (vld) begin
          m_seen++;
          m_run = (mag <= LockThr) ? m_run + 1 : 0;
          if (m_run >= LockCnt) nxt = 3;
          else if (m_seen >= AcqTimeout) begin
            nxt = 1;
            if (m_retry < 255) m_retry++;
          end
        end
        default: if (vld) begin
          m_bad_run = (mag > UnlockThr) ? m_bad_run + 1 : 0;
          if (m_bad_run >= UnlockCnt) nxt = 2;
        end
      endcase
    end
    if (r || nxt != m_mode) begin
      m_run = 0; m_seen = 0; m_bad_run = 0; m_age = 0;
    end
    m_mode = nxt;
  endtask

  task automatic step(input bit r, input bit en, input bit vld, input int e);
    rst = r;
    enable_i = en;
    err_valid_i = vld;
    phase_err_i = 24'(e);
    @(posedge clk);
    model_update(r, en, vld, e);
    #1;
    check("state", 32'(state_o), 32'(m_mode));
    check("locked", 32'(locked_o), 32'(m_mode == 3));
    check("loop_rst", 32'(loop_rst_o), 32'(m_mode <= 1));
    check("kp", 32'(kp_coeff_o), (m_mode == 3) ? 32'd322 : 32'd1288);
    check("ki", 32'(ki_coeff_o), (m_mode == 3) ? 32'd13 : 32'd208);
    check("retry", 32'(retry_cnt_o), 32'(m_retry));
  endtask

  task automatic run(input int n, input bit vld, input int e);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, vld, e);
  endtask

  initial begin
    int hi;
    int pool [12];
    bit good_regime;
    pool = '{0, 500, 1000, 1001, 1500, 4999, 5000, 5001, 6000, 20000, ErrMax, ErrMin};
    m_mode = 0; m_run = 0; m_seen = 0; m_bad_run = 0; m_age = 0; m_retry = 0;

    // Reset values
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 0);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_loop_rst", 32'(loop_rst_o), 32'd1);
    check("rst_kp", 32'(kp_coeff_o), 32'd1288);
    check("rst_ki", 32'(ki_coeff_o), 32'd208);
    check("rst_retry", 32'(retry_cnt_o), 32'd0);

    // Enable: loop_rst stays high through FLUSH_LEN cycles after the IDLE exit edge.
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b0, 0);
      if (!loop_rst_o) break;
      hi++;
    end
    check("flush_len", 32'(hi), 32'd4);
    check("acq_state", 32'(state_o), 32'd2);
    check("acq_kp", 32'(kp_coeff_o), 32'd1288);

    // Broken run does not lock, clean run of 8 does.
    run(7, 1'b1, 500);
    run(1, 1'b1, 1500);
    run(7, 1'b1, 500);
    check("no_lock", 32'(state_o), 32'd2);
    run(1, 1'b1, -500);
    check("lock_state", 32'(state_o), 32'd3);
    check("lock_locked", 32'(locked_o), 32'd1);
    check("lock_kp", 32'(kp_coeff_o), 32'd322);
    check("lock_ki", 32'(ki_coeff_o), 32'd13);

    // Unlock: exactly UNLOCK_THR is still in range; most negative code is out.
    run(3, 1'b1, 6000);
    run(1, 1'b1, 5000);
    run(3, 1'b1, ErrMin);
    check("still_track", 32'(state_o), 32'd3);
    run(1, 1'b1, 6000);
    check("unlock_state", 32'(state_o), 32'd2);
    check("unlock_locked", 32'(locked_o), 32'd0);
    check("unlock_loop_rst", 32'(loop_rst_o), 32'd0);

    // Timeout -> FLUSH with one retry, integrator cleared for FLUSH_LEN cycles.
    run(31, 1'b1, -20000);
    check("pre_timeout", 32'(state_o), 32'd2);
    run(1, 1'b1, -20000);
    check("timeout_state", 32'(state_o), 32'd1);
    check("timeout_retry", 32'(retry_cnt_o), 32'd1);
    hi = 1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b0, 0);
      if (!loop_rst_o) break;
      hi++;
    end
    check("timeout_flush", 32'(hi), 32'd4);

    // Lock and timeout on the same sample: lock wins.
    run(24, 1'b1, -20000);
    run(8, 1'b1, 1000);
    check("tie_state", 32'(state_o), 32'd3);
    check("tie_retry", 32'(retry_cnt_o), 32'd1);

    // Disable from TRACK.
    step(1'b0, 1'b0, 1'b0, 0);
    check("dis_state", 32'(state_o), 32'd0);
    check("dis_loop_rst", 32'(loop_rst_o), 32'd1);

    // Retry saturation.
    run(5, 1'b0, 0);
    for (int i = 0; i < 300; i++) run(36, 1'b1, -20000);
    check("retry_sat", 32'(retry_cnt_o), 32'd255);
    check("retry_sat_state", 32'(state_o), 32'd2);

    // Mid-operation reset.
    step(1'b1, 1'b1, 1'b1, 500);
    check("midrst_state", 32'(state_o), 32'd0);
    check("midrst_retry", 32'(retry_cnt_o), 32'd0);

    // Randomized traffic with slowly alternating good/bad error regimes.
    good_regime = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      int e;
      bit r, en, vld;
      if ($urandom_range(0, 49) == 0) good_regime = ~good_regime;
      e = good_regime ? pool[$urandom_range(0, 3)] : pool[$urandom_range(4, 11)];
      if (e != ErrMin && $urandom_range(0, 1) == 1) e = -e;
      r   = ($urandom_range(0, 999) < 3);
      en  = ($urandom_range(0, 99) < 98);
      vld = ($urandom_range(0, 3) != 0);
      step(r, en, vld, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
